afpm_operand_loader: RTL

//   Byte-serial front end of the logarithmic FP16 multiplier.
//   - Assembles two FP16 operands, A and B, from two parallel 8-bit byte lanes. Low byte arrives first.
//   - Hands each completed operand pair to the multiplier core over a valid/ready handshake.
//   - Sits between the pad-level ui_in/uio_in inputs and the multiplier core.

---
 rtl/afpm_pkg.sv | 22 ++
 rtl/afpm_fp16_classify.sv | 29 ++
 rtl/afpm_operand_loader.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/afpm_pkg.sv
// Shared types and widths for the logarithmic FP16 multiplier datapath.
package afpm_pkg;

    localparam int FP16_W = 16;
    localparam int EXP_W  = 5;
    localparam int MANT_W = 10;
    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        CLS_NORM = 2'b00,
        CLS_ZERO = 2'b01,
        CLS_INF  = 2'b10,
        CLS_NAN  = 2'b11
    } fp_cls_e;

    typedef enum logic [1:0] {
        S_LO   = 2'b00,
        S_HI   = 2'b01,
        S_FULL = 2'b10
    } loader_state_e;

endpackage

// File: rtl/afpm_fp16_classify.sv
// Combinational FP16 operand classifier (zero/subnormal, inf, NaN, normal).
// Also used by the result normaliser, so it carries no loader-specific logic.
module afpm_fp16_classify
    import afpm_pkg::*;
(
    input  logic [FP16_W-1:0] fp,
    output fp_cls_e           cls
);

    logic [EXP_W-1:0]  exp_f;
    logic [MANT_W-1:0] mant_f;
    logic              unused_sign;

    assign exp_f       = fp[FP16_W-2 -: EXP_W];
    assign mant_f      = fp[MANT_W-1:0];
    assign unused_sign = fp[FP16_W-1];

    // Decode the exponent/mantissa fields into an operand class.
    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        cls = CLS_NORM;
        if (exp_f == '0) begin
            cls = CLS_ZERO;
        end else if (exp_f == '1) begin
            cls = (mant_f == '0) ? CLS_INF : CLS_NAN;
        end
    end

endmodule

// File: rtl/afpm_operand_loader.sv
// Byte-serial operand loader: assembles FP16 A/B from two 8-bit lanes
// (low byte first) and presents each pair to the core via valid/ready.
// Optional feature macro: AFPM_LOADER_CLASSIFY_EN (operand class decode).
module afpm_operand_loader
    import afpm_pkg::*;
#(
    parameter int HOLD_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BYTE_W-1:0] in_a,
    input  logic [BYTE_W-1:0] in_b,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [FP16_W-1:0] op_a,
    output logic [FP16_W-1:0] op_b,
    output logic [1:0]        op_cls_a,
    output logic [1:0]        op_cls_b,
    output logic              frame_err
);

    localparam logic [3:0] BEAT_LAST = 4'(HOLD_CYCLES - 1);

    loader_state_e     state_q, state_d;
    logic [3:0]        beat_q, beat_d;
    logic [FP16_W-1:0] op_a_q, op_a_d;
    logic [FP16_W-1:0] op_b_q, op_b_d;
    logic              frame_err_q, frame_err_d;

    // Next-state, beat counting, byte capture and framing-error detection.
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        frame_err_d = frame_err_q;

        if (flush) begin
            state_d     = S_LO;
            beat_d      = '0;
            frame_err_d = 1'b0;
        end else begin
            case (state_q)
                S_LO, S_HI: begin
                    if (in_valid) begin
                        if (beat_q == BEAT_LAST) begin
                            beat_d = '0;
                            if (state_q == S_LO) begin
                                op_a_d[BYTE_W-1:0] = in_a;
                                op_b_d[BYTE_W-1:0] = in_b;
                                state_d            = S_HI;
                            end else begin
                                op_a_d[FP16_W-1:BYTE_W] = in_a;
                                op_b_d[FP16_W-1:BYTE_W] = in_b;
                                state_d                 = S_FULL;
                            end
                        end else begin
                            beat_d = beat_q + 4'd1;
                        end
                    end else begin
                        // Lanes went idle: abandon any partial pair.
                        beat_d  = '0;
                        state_d = S_LO;
                        if (state_q == S_HI || beat_q != '0) begin
                            frame_err_d = 1'b1;
                        end
                    end
                end
                S_FULL: begin
                    if (op_ready) begin
                        state_d = S_LO;
                    end
                end
                default: state_d = S_LO;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            state_q     <= S_LO;
            beat_q      <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign op_valid  = (state_q == S_FULL);
    assign in_ready  = (state_q != S_FULL);
    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign frame_err = frame_err_q;

`ifdef AFPM_LOADER_CLASSIFY_EN
    fp_cls_e     cls_a_q, cls_a_d, cls_new_a;
    fp_cls_e     cls_b_q, cls_b_d, cls_new_b;
    logic        hi_capture;

    // Classify the word as it will be once the high byte lands.
    afpm_fp16_classify u_cls_a (
        .fp  ({in_a, op_a_q[BYTE_W-1:0]}),
        .cls (cls_new_a)
    );

    afpm_fp16_classify u_cls_b (
        .fp  ({in_b, op_b_q[BYTE_W-1:0]}),
        .cls (cls_new_b)
    );

    assign hi_capture = !flush && (state_q == S_HI) && in_valid && (beat_q == BEAT_LAST);

    // Class registers update only together with the high-byte capture.
    always_comb begin
        cls_a_d = cls_a_q;
        cls_b_d = cls_b_q;
        if (hi_capture) begin
            cls_a_d = cls_new_a;
            cls_b_d = cls_new_b;
        end
    end

    // Class output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cls_a_q <= CLS_NORM;
            cls_b_q <= CLS_NORM;
        end else begin
            cls_a_q <= cls_a_d;
            cls_b_q <= cls_b_d;
        end
    end

    assign op_cls_a = cls_a_q;
    assign op_cls_b = cls_b_q;
`else
    assign op_cls_a = 2'b00;
    assign op_cls_b = 2'b00;
`endif

endmodule
